coin_input_conditioner: RTL and testbench

Front-end stage that feeds `vending_25c_moore`. It synchronizes and debounces the raw dime and quarter sensor lines and buffers accepted coins in a small FIFO. It then emits each coin as a single-cycle `D` or `Q` pulse, spaced so the vending FSM never sees simultaneous or back-to-back coins it would drop. Coins that cannot be buffered are flagged on `coin_reject` so the mechanism can return them.

---
 rtl/coin_input_conditioner.sv | 106 ++++++++++
 tb/tb_coin_input_conditioner.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/coin_input_conditioner.sv
// Coin sensor front end: 2-flop sync + debounce per channel, a 1-bit coin FIFO,
// and gap-spaced single-cycle D/Q pulses for the vending FSM.
module coin_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int MIN_GAP         = 3
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               dime_raw,
  input  logic                               quarter_raw,
  output logic                               D,
  output logic                               Q,
  output logic                               coin_reject,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    pending
);

  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GW  = $clog2(MIN_GAP);

  // channel index 0 = dime, 1 = quarter
  logic [1:0]     sync_p0, sync_p1, deb_lvl, deb_lvl_d;
  logic [DBW-1:0] db_cnt [2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      deb_lvl   <= '0;
      deb_lvl_d <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync_p0   <= {quarter_raw, dime_raw};
      sync_p1   <= sync_p0;
      deb_lvl_d <= deb_lvl;
      for (int ch = 0; ch < 2; ch++) begin
        if (sync_p1[ch] != deb_lvl[ch]) begin
          if (db_cnt[ch] == DBW'(DEBOUNCE_CYCLES - 1)) begin
            deb_lvl[ch] <= sync_p1[ch];
            db_cnt[ch]  <= '0;
          end else begin
            db_cnt[ch]  <= db_cnt[ch] + DBW'(1);
          end
        end else begin
          db_cnt[ch] <= '0;
        end
      end
    end
  end

  // Coin events, FIFO push/pop arbitration
  logic          dime_evt, qtr_evt, dime_acc, qtr_acc, pop;
  logic [CW:0]   free_slots;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nx;
  logic [GW-1:0] gap;
  logic          mem [FIFO_DEPTH];
  logic [1:0]    num_push;

  assign dime_evt   = deb_lvl[0] & ~deb_lvl_d[0];
  assign qtr_evt    = deb_lvl[1] & ~deb_lvl_d[1];
  assign pop        = (count != '0) && (gap == '0);
  // A concurrent pop frees its slot before pushes are judged.
  assign free_slots = (CW+1)'(FIFO_DEPTH) - {1'b0, count} + (CW+1)'(pop);
  assign dime_acc   = dime_evt && (free_slots >= (CW+1)'(1));
  assign qtr_acc    = qtr_evt && (free_slots >= (dime_acc ? (CW+1)'(2) : (CW+1)'(1)));
  assign num_push   = {1'b0, dime_acc} + {1'b0, qtr_acc};
  assign wr_ptr_nx  = wr_ptr + PW'(1);
  assign pending    = count;

  always_ff @(posedge clock) begin
    if (dime_acc) begin
      mem[wr_ptr] <= 1'b0;
      if (qtr_acc) mem[wr_ptr_nx] <= 1'b1;
    end else if (qtr_acc) begin
      mem[wr_ptr] <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      gap         <= '0;
      D           <= 1'b0;
      Q           <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + PW'(num_push);
      rd_ptr      <= rd_ptr + PW'(pop);
      count       <= count + CW'(num_push) - CW'(pop);
      D           <= pop & ~mem[rd_ptr];
      Q           <= pop & mem[rd_ptr];
      coin_reject <= (dime_evt & ~dime_acc) | (qtr_evt & ~qtr_acc);
      if (pop)
        gap <= GW'(MIN_GAP - 1);
      else if (gap != '0)
        gap <= gap - GW'(1);
    end
  end

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench: default instance for latency/debounce/spacing, a long-gap
// instance to fill the FIFO for overflow and mid-queue reset.
module tb_coin_input_conditioner;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       dime_a = 1'b0, quarter_a = 1'b0, dime_b = 1'b0, quarter_b = 1'b0;
  logic       d_a, q_a, rej_a, d_b, q_b, rej_b;
  logic [2:0] pend_a, pend_b;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int rej_a_n = 0, rej_b_n = 0, both_n = 0;
  int d_a_t[$], q_a_t[$], d_b_t[$], q_b_t[$];
  int b_seq[$];

  always #5 clock = ~clock;

  coin_input_conditioner u_dut (
    .clock(clock), .reset(reset), .dime_raw(dime_a), .quarter_raw(quarter_a),
    .D(d_a), .Q(q_a), .coin_reject(rej_a), .pending(pend_a)
  );

  coin_input_conditioner #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4), .MIN_GAP(100)) u_ovf (
    .clock(clock), .reset(reset), .dime_raw(dime_b), .quarter_raw(quarter_b),
    .D(d_b), .Q(q_b), .coin_reject(rej_b), .pending(pend_b)
  );

  always @(posedge clock) cyc = cyc + 1;

  always @(negedge clock) begin
    if (d_a) d_a_t.push_back(cyc);
    if (q_a) q_a_t.push_back(cyc);
    if (rej_a) rej_a_n++;
    if (d_b) begin d_b_t.push_back(cyc); b_seq.push_back(0); end
    if (q_b) begin q_b_t.push_back(cyc); b_seq.push_back(1); end
    if (rej_b) rej_b_n++;
    if ((d_a && q_a) || (d_b && q_b)) both_n++;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pair_b();
    dime_b = 1'b1; quarter_b = 1'b1;
    repeat (8) @(negedge clock);
    dime_b = 1'b0; quarter_b = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  typedef struct {
    bit dime;
    bit qtr;
    int width;
    int exp_nd;
    int exp_nq;
    int d_off;
    int q_off;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int k, mingap, seq_code;

    vecs[0] = '{1'b1, 1'b0, 20, 1, 0, 7, 0};
    vecs[1] = '{1'b0, 1'b1, 20, 0, 1, 0, 7};
    vecs[2] = '{1'b1, 1'b1, 20, 1, 1, 7, 10};
    vecs[3] = '{1'b1, 1'b0, 1,  0, 0, 0, 0};
    vecs[4] = '{1'b0, 1'b1, 3,  0, 0, 0, 0};
    vecs[5] = '{1'b1, 1'b0, 4,  1, 0, 7, 0};
    vecs[6] = '{1'b1, 1'b1, 3,  0, 0, 0, 0};

    #12;
    chk("rst_D", d_a, 0);
    chk("rst_Q", q_a, 0);
    chk("rst_reject", rej_a, 0);
    chk("rst_pending", pend_a, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    for (int i = 0; i < 7; i++) begin
      @(negedge clock); #1;
      d_a_t.delete(); q_a_t.delete(); rej_a_n = 0;
      k = cyc + 1;
      dime_a = vecs[i].dime; quarter_a = vecs[i].qtr;
      repeat (vecs[i].width) @(negedge clock);
      dime_a = 1'b0; quarter_a = 1'b0;
      repeat (40) @(negedge clock);
      chk($sformatf("v%0d_nD", i), d_a_t.size(), vecs[i].exp_nd);
      chk($sformatf("v%0d_nQ", i), q_a_t.size(), vecs[i].exp_nq);
      chk($sformatf("v%0d_reject", i), rej_a_n, 0);
      if (vecs[i].exp_nd > 0 && d_a_t.size() > 0)
        chk($sformatf("v%0d_D_latency", i), d_a_t[0] - k, vecs[i].d_off);
      if (vecs[i].exp_nq > 0 && q_a_t.size() > 0)
        chk($sformatf("v%0d_Q_latency", i), q_a_t[0] - k, vecs[i].q_off);
    end

    // single dime: pending 0->1->0 and a one-cycle D
    @(negedge clock); #1;
    d_a_t.delete(); q_a_t.delete();
    k = cyc + 1;
    dime_a = 1'b1;
    repeat (7) @(negedge clock);
    chk("single_pend_after_push", pend_a, 1);
    chk("single_D_before", d_a, 0);
    @(negedge clock);
    chk("single_pend_after_pop", pend_a, 0);
    chk("single_D_high", d_a, 1);
    @(negedge clock);
    chk("single_D_width", d_a, 0);
    dime_a = 1'b0;
    repeat (30) @(negedge clock);
    chk("single_nQ", q_a_t.size(), 0);

    // quarter bounce then stable rise
    @(negedge clock); #1;
    d_a_t.delete(); q_a_t.delete();
    quarter_a = 1'b1; repeat (1) @(negedge clock);
    quarter_a = 1'b0; repeat (2) @(negedge clock);
    quarter_a = 1'b1; repeat (3) @(negedge clock);
    quarter_a = 1'b0; repeat (2) @(negedge clock);
    k = cyc + 1;
    quarter_a = 1'b1; repeat (20) @(negedge clock);
    quarter_a = 1'b0; repeat (40) @(negedge clock);
    chk("bounce_nQ", q_a_t.size(), 1);
    chk("bounce_nD", d_a_t.size(), 0);
    if (q_a_t.size() > 0) chk("bounce_Q_latency", q_a_t[0] - k, 7);

    // burst of 5 dimes at 12-cycle spacing
    @(negedge clock); #1;
    d_a_t.delete(); q_a_t.delete(); rej_a_n = 0;
    for (int n = 0; n < 5; n++) begin
      dime_a = 1'b1; repeat (6) @(negedge clock);
      dime_a = 1'b0; repeat (6) @(negedge clock);
    end
    repeat (30) @(negedge clock);
    chk("burst_nD", d_a_t.size(), 5);
    chk("burst_reject", rej_a_n, 0);
    mingap = 1000;
    for (int n = 1; n < d_a_t.size(); n++)
      if (d_a_t[n] - d_a_t[n-1] < mingap) mingap = d_a_t[n] - d_a_t[n-1];
    chk("burst_spacing", mingap, 12);

    // long-gap instance: queue 3 then reset mid-queue
    @(negedge clock); #1;
    d_b_t.delete(); q_b_t.delete(); rej_b_n = 0; b_seq.delete();
    pair_b(); pair_b();
    repeat (4) @(negedge clock);
    chk("queue3_pending", pend_b, 3);
    chk("queue3_nD", d_b_t.size(), 1);
    chk("queue3_reject", rej_b_n, 0);
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    chk("midq_rst_D", d_b, 0);
    chk("midq_rst_Q", q_b, 0);
    chk("midq_rst_reject", rej_b, 0);
    chk("midq_rst_pending", pend_b, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    d_b_t.delete(); q_b_t.delete(); rej_b_n = 0; b_seq.delete();
    repeat (150) @(negedge clock);
    chk("post_rst_nD", d_b_t.size(), 0);
    chk("post_rst_nQ", q_b_t.size(), 0);
    chk("post_rst_pending", pend_b, 0);

    // overflow: 1 free slot then 0 free slots
    pair_b(); pair_b();
    chk("ovf_pending3", pend_b, 3);
    pair_b();
    chk("ovf_pending4", pend_b, 4);
    chk("ovf_reject_one_free", rej_b_n, 1);
    pair_b();
    chk("ovf_pending_full", pend_b, 4);
    chk("ovf_reject_zero_free", rej_b_n, 2);
    repeat (450) @(negedge clock);
    chk("ovf_drain_count", b_seq.size(), 5);
    seq_code = 0;
    foreach (b_seq[n]) seq_code = seq_code * 10 + b_seq[n];
    chk("ovf_drain_order", seq_code, 1010);
    chk("ovf_drain_pending", pend_b, 0);

    chk("D_Q_overlap", both_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
